// File: rtl/exe_mdu_ctrl_pkg.sv
// Shared definitions for the EX-stage multiply/divide sequencing controller.
// State encodings and default sizing live here so exec and the controller agree.
package exe_mdu_ctrl_pkg;

    localparam int MDU_DATA_W_DEF   = 32;
    localparam int MDU_WDOG_CYC_DEF = 64;

    typedef enum logic [1:0] {
        MDU_ST_IDLE = 2'd0,
        MDU_ST_MUL  = 2'd1,
        MDU_ST_DIV  = 2'd2,
        MDU_ST_DONE = 2'd3
    } mdu_state_e;

    function automatic logic mdu_is_busy(input mdu_state_e st);
        return (st == MDU_ST_MUL) || (st == MDU_ST_DIV);
    endfunction

endpackage

// File: rtl/exe_mdu_ctrl_watchdog.sv
// Busy-cycle watchdog for the MDU controller: counts cycles spent waiting on a unit
// and flags the cycle in which the count reaches WDOG_CYC.
module exe_mdu_ctrl_watchdog #(
    parameter int WDOG_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expire
);

    localparam int CNT_W = $clog2(WDOG_CYC + 1);

    logic [CNT_W-1:0] r_cnt;

    // The count freezes once expired so it cannot wrap before the FSM leaves the busy state.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_run && !o_expire) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = i_run && (r_cnt == CNT_W'(WDOG_CYC - 1));

endmodule

// File: rtl/exe_mdu_ctrl.sv
// Sequencing controller between the execute stage and the multiply/divide units.
// Optional busy-cycle watchdog is built in when MDU_WATCHDOG_EN is defined.
module exe_mdu_ctrl
    import exe_mdu_ctrl_pkg::*;
#(
    parameter int DATA_W   = MDU_DATA_W_DEF,
    parameter int WDOG_CYC = MDU_WDOG_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              I_op_valid,
    input  logic              I_op_is_div,
    input  logic              I_op_signed,
    input  logic [DATA_W-1:0] I_srca,
    input  logic [DATA_W-1:0] I_srcb,
    input  logic              I_flush,
    input  logic              I_ex_hold,
    input  logic              I_mul_ready,
    input  logic              I_div_ready,
    input  logic [DATA_W-1:0] I_unit_result,
    output logic [DATA_W-1:0] O_srca,
    output logic [DATA_W-1:0] O_srcb,
    output logic              O_mul_start,
    output logic              O_div_start,
    output logic              O_signed_div,
    output logic              O_annul,
    output logic [DATA_W-1:0] O_result,
    output logic              O_result_valid,
    output logic              O_stallreq,
    output logic              O_err,
    output logic [1:0]        O_dbg_state
);

    mdu_state_e        r_state;
    logic [DATA_W-1:0] r_srca;
    logic [DATA_W-1:0] r_srcb;
    logic              r_signed;
    logic              r_mul_start;
    logic              r_div_start;
    logic [DATA_W-1:0] r_result;
    logic              r_result_valid;
    logic              r_orphan;
    logic              r_err;

    logic w_issue;
    logic w_busy;
    logic w_keep;
    logic w_expire;

    assign w_issue = (r_state == MDU_ST_IDLE) && I_op_valid && !I_flush;
    assign w_busy  = mdu_is_busy(r_state);
    // An op that left EX while its unit was busy completes, but its result is not presented.
    assign w_keep  = I_op_valid && !r_orphan;

`ifdef MDU_WATCHDOG_EN
    exe_mdu_ctrl_watchdog #(
        .WDOG_CYC (WDOG_CYC)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_issue),
        .i_run    (w_busy),
        .o_expire (w_expire)
    );
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (WDOG_CYC > 0);
    assign w_expire     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= MDU_ST_IDLE;
            r_srca         <= '0;
            r_srcb         <= '0;
            r_signed       <= 1'b0;
            r_mul_start    <= 1'b0;
            r_div_start    <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_orphan       <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            unique case (r_state)
                MDU_ST_IDLE: begin
                    r_result_valid <= 1'b0;
                    if (w_issue) begin
                        r_srca      <= I_srca;
                        r_srcb      <= I_srcb;
                        r_signed    <= I_op_signed;
                        r_orphan    <= 1'b0;
                        r_mul_start <= !I_op_is_div;
                        r_div_start <= I_op_is_div;
                        r_state     <= I_op_is_div ? MDU_ST_DIV : MDU_ST_MUL;
                    end
                end
                MDU_ST_MUL: begin
                    r_mul_start <= 1'b0;
                    if (!I_op_valid) r_orphan <= 1'b1;
                    // A ready coinciding with the start pulse belongs to an older op.
                    if (I_flush) begin
                        r_state <= MDU_ST_IDLE;
                    end else if (I_mul_ready && !r_mul_start) begin
                        r_result       <= I_unit_result;
                        r_result_valid <= w_keep;
                        r_state        <= MDU_ST_DONE;
                    end else if (w_expire) begin
                        r_result       <= '0;
                        r_result_valid <= w_keep;
                        r_err          <= 1'b1;
                        r_state        <= MDU_ST_DONE;
                    end
                end
                MDU_ST_DIV: begin
                    if (!I_op_valid) r_orphan <= 1'b1;
                    if (I_flush) begin
                        r_div_start <= 1'b0;
                        r_state     <= MDU_ST_IDLE;
                    end else if (I_div_ready) begin
                        r_div_start    <= 1'b0;
                        r_result       <= I_unit_result;
                        r_result_valid <= w_keep;
                        r_state        <= MDU_ST_DONE;
                    end else if (w_expire) begin
                        r_div_start    <= 1'b0;
                        r_result       <= '0;
                        r_result_valid <= w_keep;
                        r_err          <= 1'b1;
                        r_state        <= MDU_ST_DONE;
                    end
                end
                MDU_ST_DONE: begin
                    if (I_flush || !I_ex_hold || !r_result_valid) begin
                        r_result_valid <= 1'b0;
                        r_state        <= MDU_ST_IDLE;
                    end
                end
                default: r_state <= MDU_ST_IDLE;
            endcase
        end
    end

    assign O_srca         = r_srca;
    assign O_srcb         = r_srcb;
    assign O_signed_div   = r_signed;
    assign O_mul_start    = r_mul_start;
    assign O_div_start    = r_div_start;
    assign O_result       = r_result;
    assign O_result_valid = r_result_valid;
    assign O_err          = r_err;
    assign O_dbg_state    = r_state;
    assign O_stallreq     = w_issue || w_busy;
    assign O_annul        = (r_state == MDU_ST_DIV) && (I_flush || (w_expire && !I_div_ready));

endmodule

// File: doc/exe_mdu_ctrl.md
Name: exe_mdu_ctrl

Overview:
Sequencing controller for the EX-stage multiply/divide units.
- Accepts a mul/div op from the execute stage and latches its operands so later forwarding changes cannot corrupt them.
- Issues the start handshake to the multiplier (one-cycle pulse) or divider (level start), raises the EX stall request while the unit is busy, and holds the result until the pipeline advances.
- Handles flush by annulling an in-flight divide.
- Replaces the ad-hoc start/stall glue inside the exec stage.

Parameters:
DATA_W, 32, operand/result width
WDOG_CYC, 64, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
I_op_valid  in  1  EX currently holds a mul/div op
I_op_is_div  in  1  1 = div/rem, 0 = mul family
I_op_signed  in  1  signed divide (DIV/REM)
I_srca  in  DATA_W  forwarded operand A
I_srcb  in  DATA_W  forwarded operand B
I_flush  in  1  kill the op in EX
I_ex_hold  in  1  downstream stall; EX cannot advance this cycle
I_mul_ready  in  1  multiplier result valid
I_div_ready  in  1  divider result valid
I_unit_result  in  DATA_W  result from the ready unit
O_srca  out  DATA_W  latched operand A to the units
O_srcb  out  DATA_W  latched operand B to the units
O_mul_start  out  1  one-cycle multiplier start pulse
O_div_start  out  1  divider start level
O_signed_div  out  1  latched signedness
O_annul  out  1  one-cycle divider abort
O_result  out  DATA_W  held result
O_result_valid  out  1  O_result valid for the op in EX
O_stallreq  out  1  stall request to the pipeline controller
O_err  out  1  sticky watchdog error (0 when the feature is disabled)

Behaviour:
- States: IDLE, MUL_BUSY, DIV_BUSY, DONE.
- Reset: state=IDLE; all outputs 0, including O_srca, O_srcb and O_result. No annul is issued on reset; the units reset themselves.
- IDLE:
  - If I_op_valid & ~I_flush: latch srca, srcb and signed; go to MUL_BUSY or DIV_BUSY.
  - O_mul_start pulses in the first MUL_BUSY cycle only.
  - O_div_start is high throughout DIV_BUSY.
  - I_mul_ready/I_div_ready seen in IDLE or DONE are ignored (stale).
- MUL_BUSY: on I_mul_ready, capture I_unit_result and go to DONE. I_mul_ready is not accepted in the same cycle as O_mul_start.
- DIV_BUSY: on I_div_ready, capture the result, drop O_div_start the next cycle, and go to DONE.
- DONE:
  - O_result_valid=1.
  - If ~I_ex_hold, go to IDLE (the op leaves EX at this edge); otherwise hold O_result and O_result_valid.
- O_stallreq (combinational):
  - (state==IDLE & I_op_valid & ~I_flush), or
  - state is MUL_BUSY or DIV_BUSY.
  - It is 0 in DONE.
- Minimum latency: issue edge to DONE is the unit latency + 1 cycle. Back-to-back ops: the second op issues in the cycle after DONE exits.
- Flush:
  - I_flush in any non-IDLE state forces IDLE at the next edge and clears O_result_valid.
  - If the state is DIV_BUSY, O_annul=1 for exactly that flush cycle, and O_div_start deasserts at the same edge.
  - Flush has priority over a same-cycle ready.
  - A late mul result after flush is ignored.
- I_op_valid dropping while busy without a flush is a protocol error; the controller still completes the op and discards the result in DONE (goes to IDLE regardless of I_ex_hold).
- Reset mid-operation behaves identically to the reset case above.

Optional Feature:
MDU_WATCHDOG_EN
- Defined:
  - A cycle counter runs while in MUL_BUSY or DIV_BUSY.
  - On reaching WDOG_CYC: set sticky O_err, pulse O_annul if dividing, force IDLE, and return result 0 with O_result_valid via DONE so the pipeline drains.
  - The counter clears on entry to each busy state.
  - O_err clears only on rst.
- Not defined: no counter, and O_err is tied to 0.

Decomposition:
- Shared defines header:
  - state encodings (MDU_ST_IDLE/MUL/DIV/DONE, 2 bits);
  - DATA_W default;
  - WDOG_CYC default.
- ALUCTL decode (mul vs div, signed) stays in exec, which drives I_op_is_div and I_op_signed.
- One natural sub-module: mdu_watchdog (counter plus compare), instantiated only under MDU_WATCHDOG_EN.

Test Plan:
1. MUL: op_valid=1, is_div=0, srca=7, srcb=6; mul_ready 3 cycles after the start pulse with result 42 -> mul_start high exactly 1 cycle, stallreq high until DONE, O_result=42 with valid for 1 cycle, then IDLE.
2. Signed DIV: srca=-20, srcb=3, signed=1; div_ready after 33 cycles, result -6 -> div_start held 33 cycles, signed_div=1, O_result=0xFFFFFFFA.
3. Flush in DIV_BUSY at cycle 10 -> annul=1 for 1 cycle, IDLE next edge, a later div_ready is ignored, result_valid stays 0.
4. DONE with ex_hold=1 for 4 cycles -> result and valid held for 4 cycles, stallreq=0; the next op issues the cycle after hold drops.
5. Operand change: srca changes from 5 to 9 mid-MUL_BUSY -> O_srca stays 5.
6. With MDU_WATCHDOG_EN and WDOG_CYC=64, div_ready never asserted -> at busy cycle 64: annul pulse, O_err=1 (sticky), O_result=0 valid; O_err stays 1 until rst.
